// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receiving end of a multiplexed 4-digit seven-segment display bus. The
// anode, segment and dot lines are sampled on every display-clock edge. The
// block follows the scan order 1110 -> 1101 -> 1011 -> 0111 and rebuilds the
// four displayed BCD digits and the dot positions. It publishes one complete
// frame at a time and counts malformed scans.
//
// Optional build macro: SEG7_SCAN_DECODER_BLANK_EN
//   defined   : an all-off segment pattern (1111111) is a valid blank code 4'hA.
//   undefined : an all-off segment pattern is undecodable (4'hF).
//
// Ports
//   divided_clk_display  in   display scan clock; all logic runs on posedge
//   reset                in   synchronous reset, active-low
//   an[3:0]              in   anode enables, active-low; an[0] = digit 0
//   seg[0:6]             in   segments a..g, active-low (seg[0] = a)
//   dp                   in   decimal point, active-low
//   digits[15:0]         out  decoded digits; digits[4i+3:4i] = digit i
//   dp_mask[3:0]         out  bit i set when the dot is lit on digit i
//   frame_valid          out  one-cycle pulse when digits/dp_mask update
//   locked               out  high after a good frame, until a sequence error
//   bad_pattern          out  one-cycle pulse for a frame with an undecodable digit
//   err_count[ERR_W-1:0] out  saturating count of sequence errors and bad frames
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int HOLD_LIMIT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             divided_clk_display,
    input  logic             reset,
    input  logic [3:0]       an,
    input  logic [0:6]       seg,
    input  logic             dp,
    output logic [15:0]      digits,
    output logic [3:0]       dp_mask,
    output logic             frame_valid,
    output logic             locked,
    output logic             bad_pattern,
    output logic [ERR_W-1:0] err_count
);

    localparam int HOLD_W = $clog2(HOLD_LIMIT + 1);

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Active-low a..g pattern -> BCD value. 4'hF marks an undecodable pattern.
    function automatic logic [3:0] seg_decode(input logic [0:6] s);
        logic [3:0] val;
        case (s)
            7'b0000001: val = 4'd0;
            7'b1001111: val = 4'd1;
            7'b0010010: val = 4'd2;
            7'b0000110: val = 4'd3;
            7'b1001100: val = 4'd4;
            7'b0100100: val = 4'd5;
            7'b0100000: val = 4'd6;
            7'b0001111: val = 4'd7;
            7'b0000000: val = 4'd8;
            7'b0000100: val = 4'd9;
`ifdef SEG7_SCAN_DECODER_BLANK_EN
            7'b1111111: val = 4'hA;
`endif
            default:    val = 4'hF;
        endcase
        return val;
    endfunction

    // Add 0..2 events to the error counter. The counter sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] base,
                                                  input logic [1:0]       inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, base} + {{(ERR_W-1){1'b0}}, inc};
        if (sum[ERR_W]) begin
            return {ERR_W{1'b1}};
        end
        return sum[ERR_W-1:0];
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         expected_q, expected_d;
    logic [1:0]         prev_q, prev_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [15:0]        shadow_dig_q, shadow_dig_d;
    logic [3:0]         shadow_dp_q, shadow_dp_d;
    logic               pend_q, pend_d;
    logic [15:0]        digits_q, digits_d;
    logic [3:0]         dp_mask_q, dp_mask_d;
    logic               frame_valid_q, frame_valid_d;
    logic               locked_q, locked_d;
    logic               bad_pattern_q, bad_pattern_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    logic               an_hit;
    logic               an_blank;
    logic [1:0]         an_idx;
    logic [3:0]         cur_dig;
    logic [HOLD_W-1:0]  hold_inc;
    logic               capture;
    logic               seq_err;
    logic               bad_inc;
    logic               shadow_ok;

    // Anode classification: exactly one low bit selects a digit, and all-high
    // means blank. Every other pattern is illegal (an_hit and an_blank both low).
    always_comb begin
        an_hit   = 1'b1;
        an_blank = 1'b0;
        an_idx   = 2'd0;
        case (an)
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            4'b1111: begin
                an_hit   = 1'b0;
                an_blank = 1'b1;
            end
            default: an_hit = 1'b0;
        endcase
    end

    assign cur_dig   = seg_decode(seg);
    assign hold_inc  = hold_q + HOLD_W'(1);
    assign shadow_ok = (shadow_dig_q[3:0]   != 4'hF) && (shadow_dig_q[7:4]   != 4'hF) &&
                       (shadow_dig_q[11:8]  != 4'hF) && (shadow_dig_q[15:12] != 4'hF);

    always_comb begin
        state_d       = state_q;
        expected_d    = expected_q;
        prev_d        = prev_q;
        hold_d        = hold_q;
        shadow_dig_d  = shadow_dig_q;
        shadow_dp_d   = shadow_dp_q;
        pend_d        = 1'b0;
        digits_d      = digits_q;
        dp_mask_d     = dp_mask_q;
        frame_valid_d = 1'b0;
        locked_d      = locked_q;
        bad_pattern_d = 1'b0;
        capture       = 1'b0;
        seq_err       = 1'b0;
        bad_inc       = 1'b0;

        // Publish the frame whose digit 3 was captured last cycle. This reads the
        // registered shadow values, so a digit-0 capture of the next frame on the
        // same edge does not disturb it.
        if (pend_q) begin
            if (shadow_ok) begin
                digits_d      = shadow_dig_q;
                dp_mask_d     = shadow_dp_q;
                frame_valid_d = 1'b1;
                locked_d      = 1'b1;
            end else begin
                bad_pattern_d = 1'b1;
                bad_inc       = 1'b1;
            end
        end

        case (state_q)
            HUNT: begin
                if (an_hit && an_idx == 2'd0) begin
                    capture    = 1'b1;
                    expected_d = 2'd1;
                    prev_d     = 2'd0;
                    hold_d     = '0;
                    state_d    = TRACK;
                end
            end
            TRACK: begin
                if (an_hit && an_idx == expected_q) begin
                    capture    = 1'b1;
                    expected_d = expected_q + 2'd1;
                    prev_d     = an_idx;
                    hold_d     = '0;
                    pend_d     = (an_idx == 2'd3);
                end else if ((an_hit && an_idx == prev_q) || an_blank) begin
                    // A digit may dwell for a few cycles. A repeat overwrites the
                    // earlier sample, and a dwell that is too long means the scan stalled.
                    if (hold_inc == HOLD_W'(HOLD_LIMIT)) begin
                        seq_err = 1'b1;
                    end else begin
                        hold_d  = hold_inc;
                        capture = an_hit;
                    end
                end else begin
                    seq_err = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase

        if (capture) begin
            shadow_dig_d[{an_idx, 2'b00} +: 4] = cur_dig;
            shadow_dp_d[an_idx]                = ~dp;
        end

        if (seq_err) begin
            state_d      = HUNT;
            expected_d   = 2'd0;
            prev_d       = 2'd0;
            hold_d       = '0;
            shadow_dig_d = '0;
            shadow_dp_d  = '0;
            locked_d     = 1'b0;
        end

        err_count_d = sat_add(err_count_q, {1'b0, seq_err} + {1'b0, bad_inc});
    end

    always_ff @(posedge divided_clk_display) begin
        if (!reset) begin
            state_q       <= HUNT;
            expected_q    <= 2'd0;
            prev_q        <= 2'd0;
            hold_q        <= '0;
            shadow_dig_q  <= '0;
            shadow_dp_q   <= '0;
            pend_q        <= 1'b0;
            digits_q      <= '0;
            dp_mask_q     <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            bad_pattern_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            prev_q        <= prev_d;
            hold_q        <= hold_d;
            shadow_dig_q  <= shadow_dig_d;
            shadow_dp_q   <= shadow_dp_d;
            pend_q        <= pend_d;
            digits_q      <= digits_d;
            dp_mask_q     <= dp_mask_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            bad_pattern_q <= bad_pattern_d;
            err_count_q   <= err_count_d;
        end
    end

    assign digits      = digits_q;
    assign dp_mask     = dp_mask_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign bad_pattern = bad_pattern_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder. Each frame the bench scans pushes its
// expected outcome into a queue. A monitor pops an entry on every
// frame_valid or bad_pattern pulse and compares it.
module tb_seg7_scan_decoder;

    localparam int HOLD_LIMIT = 4;
    localparam int ERR_W      = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       an;
    logic [0:6]       seg;
    logic             dp;
    logic [15:0]      digits;
    logic [3:0]       dp_mask;
    logic             frame_valid;
    logic             locked;
    logic             bad_pattern;
    logic [ERR_W-1:0] err_count;

    seg7_scan_decoder #(.HOLD_LIMIT(HOLD_LIMIT), .ERR_W(ERR_W)) dut (
        .divided_clk_display(clk),
        .reset(reset),
        .an(an),
        .seg(seg),
        .dp(dp),
        .digits(digits),
        .dp_mask(dp_mask),
        .frame_valid(frame_valid),
        .locked(locked),
        .bad_pattern(bad_pattern),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dpm;
        bit          bad;
    } exp_t;

    exp_t        sb[$];
    int          fv_t[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] model_digits;
    logic [3:0]  model_dpm;
    logic [0:6]  seg_tab [10];

    // Apply one bus sample. The DUT samples it on the next posedge.
    task automatic step(input logic [3:0] a, input logic [0:6] s, input logic d);
        an  = a;
        seg = s;
        dp  = d;
        @(posedge clk);
        #1;
    endtask

    // Scan one frame of four digits. bad_pos >= 0 replaces that digit's segments with ovr_seg.
    task automatic scan(input logic [15:0] val, input logic [3:0] dpm,
                        input int bad_pos, input logic [0:6] ovr_seg, input bit expect_bad);
        logic [0:6] s;
        logic [3:0] a;
        exp_t       e;
        for (int i = 0; i < 4; i++) begin
            s = (i == bad_pos) ? ovr_seg : seg_tab[val[4*i +: 4]];
            a = 4'b1111;
            a[i] = 1'b0;
            if (i == 3) begin
                if (expect_bad) begin
                    e.digits = model_digits;
                    e.dpm    = model_dpm;
                    e.bad    = 1'b1;
                end else begin
                    model_digits = val;
                    model_dpm    = dpm;
                    e.digits     = val;
                    e.dpm        = dpm;
                    e.bad        = 1'b0;
                end
                sb.push_back(e);
            end
            step(a, s, ~dpm[i]);
        end
    endtask

    task automatic drain(input string name);
        step(4'b1111, 7'b1111111, 1'b1);
        step(4'b1111, 7'b1111111, 1'b1);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_pending_frames got=%0d want=0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step(4'b1111, 7'b1111111, 1'b1);
        step(4'b1111, 7'b1111111, 1'b1);
        reset = 1'b1;
        model_digits = '0;
        model_dpm    = '0;
        sb.delete();
        fv_t.delete();
    endtask

    task automatic monitor;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (frame_valid || bad_pattern) begin
                total++;
                if (frame_valid) fv_t.push_back(cyc);
                if (frame_valid && bad_pattern) begin
                    bad++;
                    $display("FAIL pulse_overlap fv=%b bp=%b want not both", frame_valid, bad_pattern);
                end else if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_pulse fv=%b bp=%b digits=%h want no pulse",
                             frame_valid, bad_pattern, digits);
                end else begin
                    e = sb.pop_front();
                    if (bad_pattern !== e.bad || digits !== e.digits || dp_mask !== e.dpm) begin
                        bad++;
                        $display("FAIL frame got bp=%b digits=%h dp=%b want bp=%b digits=%h dp=%b",
                                 bad_pattern, digits, dp_mask, e.bad, e.digits, e.dpm);
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if ({digits, dp_mask, frame_valid, locked, bad_pattern, err_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got digits=%h dp=%b fv=%b lk=%b bp=%b err=%0d want all zero",
                     digits, dp_mask, frame_valid, locked, bad_pattern, err_count);
        end
    endtask

    task automatic test_basic;
        do_reset();
        scan(16'h3599, 4'b0010, -1, 7'b0, 1'b0);
        drain("basic");
        total++;
        if (locked !== 1'b1 || err_count !== 8'd0 || digits !== 16'h3599) begin
            bad++;
            $display("FAIL basic_state got lk=%b err=%0d digits=%h want lk=1 err=0 digits=3599",
                     locked, err_count, digits);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        scan(16'h0000, 4'b0010, -1, 7'b0, 1'b0);
        scan(16'h0001, 4'b0010, -1, 7'b0, 1'b0);
        drain("b2b");
        total++;
        if (fv_t.size() != 2) begin
            bad++;
            $display("FAIL b2b_pulse_count got=%0d want=2", fv_t.size());
        end else if (fv_t[1] - fv_t[0] != 4) begin
            bad++;
            $display("FAIL b2b_spacing got=%0d want=4", fv_t[1] - fv_t[0]);
        end
    endtask

    task automatic test_seq_error;
        do_reset();
        scan(16'h1234, 4'b0000, -1, 7'b0, 1'b0);
        drain("seq_pre");
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL seq_locked_before got=%b want=1", locked);
        end
        step(4'b1110, seg_tab[0], 1'b1);
        step(4'b1011, seg_tab[0], 1'b1);
        total++;
        if (locked !== 1'b0 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL seq_error got lk=%b err=%0d want lk=0 err=1", locked, err_count);
        end
        scan(16'h5678, 4'b1000, -1, 7'b0, 1'b0);
        drain("seq_post");
        total++;
        if (locked !== 1'b1 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL seq_relock got lk=%b err=%0d want lk=1 err=1", locked, err_count);
        end
    endtask

    task automatic test_bad_pattern;
        do_reset();
        scan(16'h4321, 4'b0001, -1, 7'b0, 1'b0);
        scan(16'h9876, 4'b0000, 2, 7'b1111110, 1'b1);
        total++;
        if (err_count !== 8'd0) begin
            bad++;
            $display("FAIL bad_err_early got=%0d want=0", err_count);
        end
        scan(16'h2468, 4'b0100, -1, 7'b0, 1'b0);
        drain("bad");
        total++;
        if (err_count !== 8'd1 || locked !== 1'b1 || digits !== 16'h2468) begin
            bad++;
            $display("FAIL bad_after got err=%0d lk=%b digits=%h want err=1 lk=1 digits=2468",
                     err_count, locked, digits);
        end
    endtask

    task automatic test_hold;
        exp_t e;
        do_reset();
        step(4'b1110, seg_tab[0], 1'b1);
        step(4'b1101, seg_tab[1], 1'b1);
        for (int i = 0; i < HOLD_LIMIT - 1; i++) step(4'b1101, seg_tab[1], 1'b1);
        total++;
        if (err_count !== 8'd0) begin
            bad++;
            $display("FAIL hold_early_err got=%0d want=0", err_count);
        end
        step(4'b1101, seg_tab[1], 1'b1);
        total++;
        if (err_count !== 8'd1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL hold_limit got err=%0d lk=%b want err=1 lk=0", err_count, locked);
        end
        do_reset();
        step(4'b1110, seg_tab[2], 1'b1);
        step(4'b1101, seg_tab[3], 1'b1);
        step(4'b1101, seg_tab[4], 1'b1);
        step(4'b1101, seg_tab[6], 1'b1);
        step(4'b1101, seg_tab[7], 1'b0);
        step(4'b1011, seg_tab[5], 1'b1);
        e.digits = 16'h1572;
        e.dpm    = 4'b0010;
        e.bad    = 1'b0;
        sb.push_back(e);
        step(4'b0111, seg_tab[1], 1'b1);
        drain("hold");
        total++;
        if (err_count !== 8'd0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL hold_ok got err=%0d lk=%b want err=0 lk=1", err_count, locked);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        scan(16'h8888, 4'b1111, -1, 7'b0, 1'b0);
        drain("mid_pre");
        step(4'b1110, seg_tab[1], 1'b1);
        step(4'b1101, seg_tab[2], 1'b1);
        reset = 1'b0;
        step(4'b1111, 7'b1111111, 1'b1);
        reset = 1'b1;
        total++;
        if ({digits, dp_mask, frame_valid, locked, bad_pattern, err_count} !== '0) begin
            bad++;
            $display("FAIL mid_reset got digits=%h dp=%b lk=%b err=%0d want all zero",
                     digits, dp_mask, locked, err_count);
        end
        step(4'b1011, seg_tab[3], 1'b1);
        step(4'b0111, seg_tab[4], 1'b1);
        drain("mid_post");
        total++;
        if (locked !== 1'b0 || err_count !== 8'd0 || digits !== 16'h0000) begin
            bad++;
            $display("FAIL mid_hunt got lk=%b err=%0d digits=%h want lk=0 err=0 digits=0000",
                     locked, err_count, digits);
        end
    endtask

    task automatic test_blank_code;
        logic [ERR_W-1:0] want_err;
        do_reset();
`ifdef SEG7_SCAN_DECODER_BLANK_EN
        scan(16'hA321, 4'b0000, 3, 7'b1111111, 1'b0);
        want_err = 8'd0;
`else
        scan(16'hA321, 4'b0000, 3, 7'b1111111, 1'b1);
        want_err = 8'd1;
`endif
        drain("blank");
        total++;
        if (err_count !== want_err) begin
            bad++;
            $display("FAIL blank_err got=%0d want=%0d", err_count, want_err);
        end
    endtask

    task automatic test_saturate;
        do_reset();
        for (int i = 0; i < 260; i++) begin
            step(4'b1110, seg_tab[0], 1'b1);
            step(4'b1011, seg_tab[0], 1'b1);
        end
        total++;
        if (err_count !== 8'hFF) begin
            bad++;
            $display("FAIL saturate got=%0d want=255", err_count);
        end
    endtask

    initial begin
        seg_tab[0] = 7'b0000001;
        seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100;
        seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000;
        seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;
        reset        = 1'b0;
        an           = 4'b1111;
        seg          = 7'b1111111;
        dp           = 1'b1;
        model_digits = '0;
        model_dpm    = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_back_to_back();
        test_seq_error();
        test_bad_pattern();
        test_hold();
        test_reset_mid();
        test_blank_code();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
